// File: rtl/spike_ingress_arbiter.sv
// rtl/spike_ingress_arbiter.sv - round-robin spike source arbiter with fault drain window
//
// Purpose: shares the grid's single spike input between NUM_REQ sources. One
// requester is granted per cycle by round-robin, and its operand pair is
// forwarded as a registered beat. A rising edge on fault_in quiesces the grid
// input for DRAIN_CYCLES cycles so the grid can reroute around the failed node.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         per-requester spike pending
//   req_data_a/_b     packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready         one-hot grant (combinational)
//   fault_in          fault level from the monitor
//   grid_valid        registered beat valid
//   grid_data_a/_b    registered operands of the granted requester
//   grid_fault        registered copy of fault_in
//   grant_id          requester index carried by the current beat
//   reroute_busy      high while draining
//   grant_total       saturating grant counter (SPIKE_ARB_STATS_EN), else 0
//
// Optional feature macro: SPIKE_ARB_STATS_EN
module spike_ingress_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 6,
  parameter int ID_W         = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_b,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fault_in,
  output logic                      grid_valid,
  output logic [DATA_W-1:0]         grid_data_a,
  output logic [DATA_W-1:0]         grid_data_b,
  output logic                      grid_fault,
  output logic [ID_W-1:0]           grant_id,
  output logic                      reroute_busy,
  output logic [15:0]               grant_total
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [7:0]      drain_cnt, drain_cnt_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic            fault_q;
  logic            fault_rise;
  logic            grant;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] idx;

  assign fault_rise = fault_in & ~fault_q;

  // Round-robin search starting just after the last granted requester.
  // rst_n is folded in so req_ready reads 0 while reset is asserted.
  always_comb begin
    grant     = 1'b0;
    grant_idx = rr_ptr;
    idx       = rr_ptr;
    req_ready = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant && req_valid[idx]) begin
        grant     = 1'b1;
        grant_idx = idx;
      end
    end
    if (!rst_n || state != RUN || fault_rise) begin
      grant = 1'b0;
    end
    if (grant) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next state and drain counter. A rising edge in DRAIN restarts the window.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (fault_rise) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = 8'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (fault_rise) begin
          drain_cnt_nxt = 8'(DRAIN_CYCLES);
        end else if (drain_cnt == 8'd1) begin
          state_nxt     = RUN;
          drain_cnt_nxt = 8'd0;
        end else begin
          drain_cnt_nxt = drain_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt     = RUN;
        drain_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      drain_cnt    <= 8'd0;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      fault_q      <= 1'b0;
      grid_valid   <= 1'b0;
      grid_data_a  <= '0;
      grid_data_b  <= '0;
      grant_id     <= '0;
      reroute_busy <= 1'b0;
    end else begin
      state        <= state_nxt;
      drain_cnt    <= drain_cnt_nxt;
      fault_q      <= fault_in;
      reroute_busy <= (state_nxt == DRAIN);
      grid_valid   <= grant;
      if (grant) begin
        rr_ptr      <= grant_idx;
        grant_id    <= grant_idx;
        grid_data_a <= req_data_a[int'(grant_idx)*DATA_W +: DATA_W];
        grid_data_b <= req_data_b[int'(grant_idx)*DATA_W +: DATA_W];
      end
    end
  end

  assign grid_fault = fault_q;

`ifdef SPIKE_ARB_STATS_EN
  logic [15:0] grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= 16'h0000;
    end else if (grant && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'h0001;
    end
  end

  assign grant_total = grant_cnt;
`else
  assign grant_total = 16'h0000;
`endif

endmodule

// File: tb/tb_spike_ingress_arbiter.sv
// tb/tb_spike_ingress_arbiter.sv - directed vector bench for spike_ingress_arbiter
module tb_spike_ingress_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data_a;
  logic [31:0] req_data_b;
  logic [3:0]  req_ready;
  logic        fault_in;
  logic        grid_valid;
  logic [7:0]  grid_data_a;
  logic [7:0]  grid_data_b;
  logic        grid_fault;
  logic [1:0]  grant_id;
  logic        reroute_busy;
  logic [15:0] grant_total;

  int checks = 0;
  int errors = 0;

  spike_ingress_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .DRAIN_CYCLES(6), .ID_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data_a(req_data_a), .req_data_b(req_data_b),
    .req_ready(req_ready), .fault_in(fault_in),
    .grid_valid(grid_valid), .grid_data_a(grid_data_a), .grid_data_b(grid_data_b),
    .grid_fault(grid_fault), .grant_id(grant_id),
    .reroute_busy(reroute_busy), .grant_total(grant_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ready;
    logic        gv;
    logic [7:0]  ga;
    logic [7:0]  gb;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  logic [31:0] da, db, ta, tb2;

  initial begin
    da  = {8'h43, 8'h42, 8'h41, 8'h40};
    db  = {8'h83, 8'h82, 8'h81, 8'h80};
    ta  = {8'h43, 8'd10, 8'h41, 8'h40};
    tb2 = {8'h83, 8'd5,  8'h81, 8'h80};

    // saturated start after reset, then single requester 2, then 3 beats 0
    vecs[0] = '{4'b1111, da,  db,  4'b0001, 1'b0, 8'h00, 8'h00, 2'd0};
    vecs[1] = '{4'b1111, da,  db,  4'b0010, 1'b1, 8'h40, 8'h80, 2'd0};
    vecs[2] = '{4'b1111, da,  db,  4'b0100, 1'b1, 8'h41, 8'h81, 2'd1};
    vecs[3] = '{4'b1111, da,  db,  4'b1000, 1'b1, 8'h42, 8'h82, 2'd2};
    vecs[4] = '{4'b1111, da,  db,  4'b0001, 1'b1, 8'h43, 8'h83, 2'd3};
    vecs[5] = '{4'b0100, ta,  tb2, 4'b0100, 1'b1, 8'h40, 8'h80, 2'd0};
    vecs[6] = '{4'b1001, da,  db,  4'b1000, 1'b1, 8'd10, 8'd5,  2'd2};
    vecs[7] = '{4'b0000, da,  db,  4'b0000, 1'b1, 8'h43, 8'h83, 2'd3};
    vecs[8] = '{4'b0000, da,  db,  4'b0000, 1'b0, 8'h43, 8'h83, 2'd3};

    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_data_a = da;
    req_data_b = db;
    fault_in   = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_gvalid", 32'(grid_valid), 32'h0);
    chk("rst_gdata_a", 32'(grid_data_a), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(reroute_busy), 32'h0);
    chk("rst_total", 32'(grant_total), 32'h0);

    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) next_cycle();
      req_valid  = vecs[i].valid;
      req_data_a = vecs[i].a;
      req_data_b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d_gvalid", i), 32'(grid_valid), 32'(vecs[i].gv));
      chk($sformatf("vec%0d_ga", i), 32'(grid_data_a), 32'(vecs[i].ga));
      chk($sformatf("vec%0d_gb", i), 32'(grid_data_b), 32'(vecs[i].gb));
      chk($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(vecs[i].id));
    end

    // single fault rising edge under saturation; rr_ptr is 3 here
    next_cycle();
    req_valid = 4'b1111; req_data_a = da; req_data_b = db;
    #1 chk("t3_pre_ready", 32'(req_ready), 32'b0001);
    next_cycle();
    fault_in = 1'b1;
    #1 chk("t3_edge_ready", 32'(req_ready), 32'h0);
    chk("t3_edge_busy", 32'(reroute_busy), 32'h0);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      #1;
      chk($sformatf("t3_drain%0d_busy", c), 32'(reroute_busy), 32'h1);
      chk($sformatf("t3_drain%0d_ready", c), 32'(req_ready), 32'h0);
      chk($sformatf("t3_drain%0d_gvalid", c), 32'(grid_valid), 32'h0);
      if (c == 0) chk("t3_gfault", 32'(grid_fault), 32'h1);
    end
    next_cycle();
    #1;
    chk("t3_end_busy", 32'(reroute_busy), 32'h0);
    chk("t3_resume_ready", 32'(req_ready), 32'b0010);
    next_cycle();
    #1;
    chk("t3_resume2_ready", 32'(req_ready), 32'b0100);
    chk("t3_resume_gvalid", 32'(grid_valid), 32'h1);
    chk("t3_resume_gid", 32'(grant_id), 32'd1);

    // drain extended by a second edge at drain cycle 4; rr_ptr is 2 here
    next_cycle();
    req_valid = 4'b0000; fault_in = 1'b0;
    next_cycle();
    req_valid = 4'b1111; fault_in = 1'b1;
    #1 chk("t4_edge_ready", 32'(req_ready), 32'h0);
    for (int d = 1; d <= 10; d++) begin
      next_cycle();
      fault_in = (d >= 4);
      #1;
      chk($sformatf("t4_drain%0d_busy", d), 32'(reroute_busy), 32'h1);
      chk($sformatf("t4_drain%0d_ready", d), 32'(req_ready), 32'h0);
    end
    next_cycle();
    #1;
    chk("t4_end_busy", 32'(reroute_busy), 32'h0);
    chk("t4_resume_ready", 32'(req_ready), 32'b1000);
    next_cycle();
    #1;
    chk("t4_held_busy", 32'(reroute_busy), 32'h0);
    chk("t4_held_ready", 32'(req_ready), 32'b0001);

    // reset asserted mid-drain; rr_ptr is 0 before reset
    next_cycle();
    req_valid = 4'b0000; fault_in = 1'b0;
    next_cycle();
    fault_in = 1'b1;
    next_cycle();
    #1;
    chk("t5_busy", 32'(reroute_busy), 32'h1);
    chk("t5_gfault", 32'(grid_fault), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(reroute_busy), 32'h0);
    chk("t5_rst_gfault", 32'(grid_fault), 32'h0);
    chk("t5_rst_gvalid", 32'(grid_valid), 32'h0);
    chk("t5_rst_gdata_a", 32'(grid_data_a), 32'h0);
    chk("t5_rst_gdata_b", 32'(grid_data_b), 32'h0);
    chk("t5_rst_gid", 32'(grant_id), 32'h0);
    chk("t5_rst_total", 32'(grant_total), 32'h0);
    next_cycle();
    rst_n = 1'b1; fault_in = 1'b0; req_valid = 4'b1111;
    #1;
    chk("t5_post_ready", 32'(req_ready), 32'b0001);
    chk("t5_post_busy", 32'(reroute_busy), 32'h0);

    // grant counter
`ifdef SPIKE_ARB_STATS_EN
    next_cycle();
    req_valid = 4'b0000;
    force dut.grant_cnt = 16'hFFFD;
    next_cycle();
    release dut.grant_cnt;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) next_cycle();
    req_valid = 4'b0000;
    #1 chk("t6_total_sat", 32'(grant_total), 32'hFFFF);
`else
    for (int g = 0; g < 5; g++) next_cycle();
    req_valid = 4'b0000;
    #1 chk("t6_total_off", 32'(grant_total), 32'h0);
    chk("t6_gvalid", 32'(grid_valid), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
